// File: rtl/channel_interleaver.sv
// channel_interleaver: four 24-bit sample streams, one FIFO each, merged
// into a single 32-bit stream in strict channel order 0,1,2,3,0,...
// Samples are sign-extended on output; tuser carries the channel index and
// tlast marks channel 3 (the end of a frame).
//
// Handshake semantics (all ports): a transfer happens on a rising edge of
// s_axis_aclk where tvalid and tready are both high. A source holds tvalid
// and its payload stable until the transfer; sN_axis_tready is a
// registered "FIFO not full" flag and never looks at m_axis_tready.
module channel_interleaver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_arstn,

  input  logic [23:0] s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,

  input  logic [23:0] s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,

  input  logic [23:0] s2_axis_tdata,
  input  logic        s2_axis_tvalid,
  output logic        s2_axis_tready,

  input  logic [23:0] s3_axis_tdata,
  input  logic        s3_axis_tvalid,
  output logic        s3_axis_tready,

  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [1:0]  m_axis_tuser,
  output logic        m_axis_tlast
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Per-channel views of the flat port list so the FIFOs can be generated.
  logic [23:0] in_data  [4];
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [23:0] head     [4];
  logic [3:0]  nonempty;

  // Output-side state: channel pointer and the load strobe shared by all
  // FIFOs (only the FIFO selected by cur is popped).
  logic [1:0]  cur;
  logic        load;
  logic [23:0] sel_head;

  assign in_data[0] = s0_axis_tdata;
  assign in_data[1] = s1_axis_tdata;
  assign in_data[2] = s2_axis_tdata;
  assign in_data[3] = s3_axis_tdata;

  assign in_valid = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};

  assign s0_axis_tready = in_ready[0];
  assign s1_axis_tready = in_ready[1];
  assign s2_axis_tready = in_ready[2];
  assign s3_axis_tready = in_ready[3];

  // The output register takes a new sample when the selected channel has
  // data and the register is empty or being drained this edge. An empty
  // selected channel stalls everything behind it: order is never broken.
  assign load     = nonempty[cur] && (!m_axis_tvalid || m_axis_tready);
  assign sel_head = head[cur];

  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic [23:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             rdy;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO has rdy low, so a write can never land on a full buffer;
    // space freed by a read only becomes visible on the following cycle.
    assign wr_en = in_valid[n] && rdy;
    assign rd_en = load && (cur == 2'(n));

    // Next occupancy: a simultaneous read and write cancel out.
    always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en) begin
        count_nxt = count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count_nxt = count - CNT_W'(1);
      end
    end

    // Pointers, occupancy and the registered ready flag. rdy is held low in
    // reset and rises on the first edge after release.
    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
      if (!s_axis_arstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        rdy    <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count_nxt;
        rdy   <= (count_nxt != FULL_CNT);
      end
    end

    // Sample storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge s_axis_aclk) begin
      if (wr_en) begin
        mem[wr_ptr] <= in_data[n];
      end
    end

    assign head[n]     = mem[rd_ptr];
    assign nonempty[n] = (count != '0);
    assign in_ready[n] = rdy;
  end

  // Output register and channel pointer. Payload only changes on load, so
  // it is stable for as long as the downstream stalls.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      cur           <= 2'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'd0;
      m_axis_tuser  <= 2'd0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      cur           <= cur + 2'd1;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {{8{sel_head[23]}}, sel_head};
      m_axis_tuser  <= cur;
      m_axis_tlast  <= (cur == 2'd3);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_channel_interleaver.sv
// Bench for channel_interleaver: directed scenarios push the expected
// output words into exp_q; a negedge monitor pops and compares on every
// output transfer and also checks payload stability while stalled.
module tb_channel_interleaver;

  logic        clk;
  logic        rst_n;
  logic [23:0] s_data  [4];
  logic        s_valid [4];
  logic        r0, r1, r2, r3;
  logic [3:0]  s_ready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [1:0]  m_tuser;
  logic        m_tlast;

  logic [34:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic        prev_stall = 1'b0;
  logic [34:0] held_word  = '0;

  assign s_ready = {r3, r2, r1, r0};

  channel_interleaver #(.FIFO_DEPTH(4)) dut (
    .s_axis_aclk    (clk),
    .s_axis_arstn   (rst_n),
    .s0_axis_tdata  (s_data[0]),
    .s0_axis_tvalid (s_valid[0]),
    .s0_axis_tready (r0),
    .s1_axis_tdata  (s_data[1]),
    .s1_axis_tvalid (s_valid[1]),
    .s1_axis_tready (r1),
    .s2_axis_tdata  (s_data[2]),
    .s2_axis_tvalid (s_valid[2]),
    .s2_axis_tready (r2),
    .s3_axis_tdata  (s_data[3]),
    .s3_axis_tvalid (s_valid[3]),
    .s3_axis_tready (r3),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected event did not occur", name);
  endtask

  function automatic logic [34:0] exp_word(input logic [1:0] u, input logic [31:0] d);
    return {u, (u == 2'd3), d};
  endfunction

  function automatic logic [31:0] sext(input logic [23:0] d);
    return {{8{d[23]}}, d};
  endfunction

  function automatic logic [23:0] pat_data(input int f, input int ch);
    logic [1:0] c;
    c = 2'(ch);
    return {c[0], 7'(f), 4'(ch), 12'hA5C};
  endfunction

  task automatic push_exp(input logic [1:0] u, input logic [31:0] d);
    exp_q.push_back(exp_word(u, d));
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_sample(input int ch, input logic [23:0] d);
    int t;
    @(posedge clk);
    #1;
    s_data[ch]  = d;
    s_valid[ch] = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready[ch]) break;
      t++;
      if (t > 300) begin
        fail_timeout($sformatf("write_ch%0d", ch));
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) s_valid[i] = 1'b0;
    m_tready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_stable", 64'({m_tvalid, m_tuser, m_tlast, m_tdata}),
              64'({1'b1, held_word}));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({m_tuser, m_tlast, m_tdata}), 64'h7_FFFF_FFFF_F);
        end else begin
          check("out_word", 64'({m_tuser, m_tlast, m_tdata}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      held_word  = {m_tuser, m_tlast, m_tdata};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] tpat;
    logic       bp_done;
    logic       ok;
    int         t;

    for (int i = 0; i < 4; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = 24'd0;
    end
    m_tready = 1'b0;
    rst_n    = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    // Reset state, before any clock edge.
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata",  64'(m_tdata),  64'd0);
    check("rst_tuser",  64'(m_tuser),  64'd0);
    check("rst_tlast",  64'(m_tlast),  64'd0);
    check("rst_tready", 64'(s_ready),  64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("tready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("tready_first_edge", 64'(s_ready), 64'hF);

    // ---- basic interleave ----
    m_tready = 1'b1;
    push_exp(2'd0, 32'h0000_0001);
    push_exp(2'd1, 32'h007F_FFFF);
    push_exp(2'd2, 32'hFF80_0000);
    push_exp(2'd3, 32'hFFFF_FFFF);
    write_sample(0, 24'h000001);
    write_sample(1, 24'h7FFFFF);
    write_sample(2, 24'h800000);
    write_sample(3, 24'hFFFFFF);
    wait_drain("basic_drain");

    // ---- latency: selected, empty FIFO, free output ----
    do_reset();
    m_tready = 1'b1;
    push_exp(2'd0, 32'h0000_0042);
    @(posedge clk);
    #1;
    s_data[0]  = 24'h000042;
    s_valid[0] = 1'b1;
    @(posedge clk);            // write edge k
    #1;
    s_valid[0] = 1'b0;
    check("lat_k", 64'(m_tvalid), 64'd0);
    @(posedge clk);            // edge k+1
    #1;
    check("lat_k1", 64'({m_tvalid, m_tuser}), 64'({1'b1, 2'd0}));
    wait_drain("lat_drain");

    // ---- strict order ----
    do_reset();
    m_tready = 1'b1;
    push_exp(2'd0, 32'hFFFE_DCBA);
    push_exp(2'd1, 32'h0012_3456);
    push_exp(2'd2, 32'hFFAB_CDEF);
    push_exp(2'd3, 32'h0000_0100);
    write_sample(1, 24'h123456);
    write_sample(2, 24'hABCDEF);
    write_sample(3, 24'h000100);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (m_tvalid) ok = 1'b0;
    end
    check("order_no_output", 64'(ok), 64'd1);
    write_sample(0, 24'hFEDCBA);
    wait_drain("order_drain");

    // ---- backpressure: 8 frames, tready pattern 1,0,0,1 ----
    do_reset();
    tpat    = 4'b1001;
    bp_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          for (int ch = 0; ch < 4; ch++) begin
            push_exp(2'(ch), sext(pat_data(f, ch)));
            write_sample(ch, pat_data(f, ch));
          end
        end
        wait_drain("bp_drain");
        bp_done = 1'b1;
      end
      begin
        int i;
        i = 0;
        while (!bp_done) begin
          @(posedge clk);
          #1;
          m_tready = tpat[i % 4];
          i++;
        end
      end
    join
    m_tready = 1'b1;

    // ---- full FIFO on ch2 with ch0 empty ----
    do_reset();
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) write_sample(2, 24'h200000 + 24'(k));
    check("full_ready_low", 64'(s_ready[2]), 64'd0);
    check("full_no_output", 64'(m_tvalid), 64'd0);
    s_data[2]  = 24'h200005;
    s_valid[2] = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (s_ready[2]) ok = 1'b0;
    end
    check("full_hold_off", 64'(ok), 64'd1);
    push_exp(2'd0, 32'h0000_0A00);
    push_exp(2'd1, 32'h0000_0B00);
    push_exp(2'd2, 32'h0020_0001);
    write_sample(0, 24'h000A00);
    write_sample(1, 24'h000B00);
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready[2]) break;
      t++;
      if (t > 50) begin
        fail_timeout("full_fifth_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid[2] = 1'b0;
    check("full_again", 64'(s_ready[2]), 64'd0);
    wait_drain("full_drain");

    // ---- throughput: all FIFOs full, tready high ----
    do_reset();
    m_tready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int ch = 0; ch < 4; ch++) begin
        push_exp(2'(ch), sext(pat_data(f, ch)));
        write_sample(ch, pat_data(f, ch));
      end
    end
    push_exp(2'd0, sext(pat_data(4, 0)));
    write_sample(0, pat_data(4, 0));
    check("tput_all_full", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("tput_cycle%0d", i), 64'({m_tvalid, m_tuser}), 64'({1'b1, 2'(i % 4)}));
    end
    wait_drain("tput_drain");

    // ---- reset mid-stream while u2 is presented ----
    do_reset();
    m_tready = 1'b1;
    push_exp(2'd0, 32'h0000_0011);
    push_exp(2'd1, 32'h0000_0022);
    write_sample(0, 24'h000011);
    write_sample(1, 24'h000022);
    wait_drain("mid_pre_drain");
    m_tready = 1'b0;
    write_sample(2, 24'h000033);
    t = 0;
    while (!m_tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_u2_shown", 64'({m_tvalid, m_tuser, m_tdata}), 64'({1'b1, 2'd2, 32'h0000_0033}));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 64'({m_tvalid, m_tuser, m_tlast, m_tdata}), 64'd0);
    check("mid_rst_ready", 64'(s_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_ready_back", 64'(s_ready), 64'hF);
    m_tready = 1'b1;
    push_exp(2'd0, 32'h0000_0101);
    push_exp(2'd1, 32'h0000_0202);
    push_exp(2'd2, 32'h0000_0303);
    push_exp(2'd3, 32'h0000_0404);
    write_sample(0, 24'h000101);
    write_sample(1, 24'h000202);
    write_sample(2, 24'h000303);
    write_sample(3, 24'h000404);
    wait_drain("mid_post_drain");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/channel_interleaver.md
CHANNEL_INTERLEAVER -- requirements
Module: channel_interleaver

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning per-channel buffer depth in samples; legal values are powers of two, 2 to 64.
REQ-002 The block SHALL have port s_axis_aclk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-003 The block SHALL have port s_axis_arstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports sN_axis_tdata (N=0..3), input, 24 bits: signed sample for channel N.
REQ-005 The block SHALL have ports sN_axis_tvalid (N=0..3), input, 1 bit: channel N sample valid.
REQ-006 The block SHALL have ports sN_axis_tready (N=0..3), output, 1 bit: channel N buffer can accept a sample.
REQ-007 The block SHALL have port m_axis_tdata, output, 32 bits: signed interleaved sample.
REQ-008 The block SHALL have port m_axis_tvalid, output, 1 bit: output sample valid.
REQ-009 The block SHALL have port m_axis_tready, input, 1 bit: downstream accepts.
REQ-010 The block SHALL have port m_axis_tuser, output, 2 bits: channel index of the current output sample.
REQ-011 The block SHALL have port m_axis_tlast, output, 1 bit: high exactly when m_axis_tuser equals 3, marking the end of a frame.

Function
REQ-012 Each channel SHALL have an independent FIFO of FIFO_DEPTH entries, with count width log2(FIFO_DEPTH)+1.
REQ-013 sN_axis_tready SHALL equal "FIFO N not full", depending only on the registered count and never on m_axis_tready.
REQ-014 A write to FIFO N SHALL occur on every edge where sN_axis_tvalid and sN_axis_tready are both high.
REQ-015 A 2-bit channel pointer cur SHALL select the next channel to output, in strict order 0,1,2,3,0,...; channels are never skipped.
REQ-016 The output register SHALL load from the head of FIFO cur on an edge where FIFO cur is non-empty and (m_axis_tvalid is low or m_axis_tready is high); cur then increments modulo 4.
REQ-017 If FIFO cur is empty, the pointer SHALL hold, and the output SHALL drain its current sample (if any) then deassert m_axis_tvalid; later channels are not served.
REQ-018 On load, m_axis_tdata SHALL be the 24-bit sample sign-extended to 32 bits, with m_axis_tuser = cur and m_axis_tlast = (cur == 3).
REQ-019 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL remain stable.
REQ-020 Latency SHALL be: a sample written at edge k into an empty FIFO that is currently selected, with the output free, appears with m_axis_tvalid high after edge k+1.
REQ-021 With all FIFOs non-empty and m_axis_tready held high, the block SHALL output one sample per cycle.
REQ-022 A simultaneous write and read of the same FIFO SHALL leave its count unchanged and return the older sample.
REQ-023 A write to a full FIFO SHALL be impossible, because its tready is low; the FIFO SHALL NOT accept a sample on an edge where a read frees space, and the write happens one cycle later.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with no loss or reordering of samples.

Reset
REQ-025 While s_axis_arstn is low, regardless of the clock: all FIFO counts and pointers SHALL be 0, cur = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0, and all sN_axis_tready = 0.
REQ-026 After reset deasserts, sN_axis_tready SHALL go high on the first clock edge.
REQ-027 A reset asserted mid-operation SHALL discard all buffered samples and any pending output; the first output after reset is channel 0.

Verification
REQ-028 Scenario, basic interleave: write ch0=0x000001, ch1=0x7FFFFF, ch2=0x800000, ch3=0xFFFFFF, with m_axis_tready held high -> outputs 0x00000001/u0, 0x007FFFFF/u1, 0xFF800000/u2, 0xFFFFFFFF/u3 with tlast=1, in that order.
REQ-029 Scenario, strict order: fill ch1..ch3 only -> no output; then write ch0 -> four outputs in the order u0,u1,u2,u3.
REQ-030 Scenario, backpressure: 8 frames written, with m_axis_tready toggling 1,0,0,1 -> every sample is output exactly once, in order, and data is stable while stalled.
REQ-031 Scenario, full FIFO: write 5 samples into ch2 with FIFO_DEPTH=4 and ch0 empty -> s2_axis_tready goes low after the 4th write; the 5th is accepted only after ch2 is drained.
REQ-032 Scenario, throughput: all FIFOs full and m_axis_tready high -> 16 consecutive cycles with m_axis_tvalid high, and tuser cycling 0,1,2,3.
REQ-033 Scenario, reset mid-stream: assert s_axis_arstn low between clock edges while outputting u2 -> m_axis_tvalid drops immediately; after release with a fresh frame, the first output is u0.
